// File: rtl/prefetch_queue_if.sv
// Memory read bus between the prefetch queue (master) and instruction memory (slave).
// Read data is valid the cycle after an accepted request.
interface prefetch_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_rd;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_gnt,
        output mem_rdata
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch buffer: streams sequential bytes ahead of the PC into a circular
// queue, presents the three head bytes in parallel and retires 1..3 bytes per cycle.
module prefetch_queue #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    prefetch_queue_if.master        mem,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   flush_addr,
    input  logic [1:0]              pop_len,
    output logic [DATA_WIDTH-1:0]   q0,
    output logic [DATA_WIDTH-1:0]   q1,
    output logic [DATA_WIDTH-1:0]   q2,
    output logic [$clog2(DEPTH):0]  level,
    output logic [ADDR_WIDTH-1:0]   head_addr,
    output logic                    underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  inflight;
    logic                  drop;
    logic                  accept;
    logic                  wr_en;
    logic                  pop_ok;
    logic [LVL_W-1:0]      pop_amt;

    assign pop_amt = LVL_W'(pop_len);

    // Room check counts the outstanding read but never credits a same-cycle pop.
    assign mem.mem_rd   = reset_n && !flush &&
                          ((level + LVL_W'(inflight)) < LVL_W'(DEPTH));
    assign mem.mem_addr = fetch_addr;
    assign accept       = mem.mem_rd && mem.mem_gnt;
    assign wr_en        = inflight && !drop && !flush;
    assign pop_ok       = !flush && (pop_len != 2'd0) && (pop_amt <= level);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            head_addr  <= BASE_ADDR;
            fetch_addr <= BASE_ADDR;
            inflight   <= 1'b0;
            drop       <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            inflight <= accept;
            drop     <= flush;
            if (flush) begin
                level      <= '0;
                rd_ptr     <= wr_ptr;
                head_addr  <= flush_addr;
                fetch_addr <= flush_addr;
                underflow  <= 1'b0;
            end else begin
                underflow <= (pop_amt > level);
                level     <= level + LVL_W'(wr_en) - (pop_ok ? pop_amt : '0);
                if (accept)
                    fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
                if (wr_en)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok) begin
                    rd_ptr    <= rd_ptr + PTR_W'(pop_len);
                    head_addr <= head_addr + ADDR_WIDTH'(pop_len);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            store[wr_ptr] <= mem.mem_rdata;
    end

    assign q0 = store[rd_ptr];
    assign q1 = store[rd_ptr + PTR_W'(1)];
    assign q2 = store[rd_ptr + PTR_W'(2)];
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus random traffic checked against a
// byte-queue model of the prefetch buffer and a random memory image.
module tb_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flush_addr = '0;
    logic [1:0]  pop_len = '0;
    logic [7:0]  q0, q1, q2;
    logic [2:0]  level;
    logic [15:0] head_addr;
    logic        underflow;

    prefetch_queue_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) mif ();

    prefetch_queue #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(DEPTH), .BASE_ADDR(16'h0010)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mem(mif), .flush(flush), .flush_addr(flush_addr),
        .pop_len(pop_len), .q0(q0), .q1(q1), .q2(q2), .level(level),
        .head_addr(head_addr), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_img [65536];

    // Memory: data for an accepted address appears the next cycle, junk otherwise.
    always @(posedge clk) begin
        if (mif.mem_rd && mif.mem_gnt)
            mif.mem_rdata <= mem_img[mif.mem_addr];
        else
            mif.mem_rdata <= 8'($urandom);
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the queue holds exactly the bytes the consumer can see.
    logic [7:0]  m_bytes[$];
    logic [15:0] m_head, m_fetch, m_infl_addr;
    int          m_infl;
    logic        m_uf;
    logic        obs_rd, exp_rd;
    logic [15:0] obs_addr, exp_addr;

    function automatic int m_level();
        return m_bytes.size();
    endfunction

    function automatic logic [7:0] dq(input int k);
        case (k)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        m_head = 16'h0010;
        m_fetch = 16'h0010;
        m_infl = 0;
        m_uf = 1'b0;
    endtask

    task automatic tick(input logic fl, input logic [15:0] fa, input logic [1:0] pl,
                        input logic g);
        bit legal;
        flush = fl;
        flush_addr = fa;
        pop_len = pl;
        mif.mem_gnt = g;
        #4;
        obs_rd = mif.mem_rd;
        obs_addr = mif.mem_addr;
        exp_rd = !fl && (m_level() + m_infl < DEPTH);
        exp_addr = m_fetch;
        @(posedge clk);
        if (fl) begin
            m_bytes.delete();
            m_head = fa;
            m_fetch = fa;
            m_infl = 0;
            m_uf = 1'b0;
        end else begin
            legal = (pl != 0) && (int'(pl) <= m_level());
            m_uf = (int'(pl) > m_level());
            if (legal) begin
                for (int i = 0; i < int'(pl); i++) void'(m_bytes.pop_front());
                m_head = m_head + 16'(pl);
            end
            if (m_infl != 0) m_bytes.push_back(mem_img[m_infl_addr]);
            if (exp_rd && g) begin
                m_infl = 1;
                m_infl_addr = m_fetch;
                m_fetch = m_fetch + 16'd1;
            end else begin
                m_infl = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        mif.mem_gnt = 1'b1;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        vectors++;
        if (level !== 3'd0) begin
            miscompares++; $display("FAIL reset_level: got %0d want 0", level);
        end
        vectors++;
        if (head_addr !== 16'h0010) begin
            miscompares++; $display("FAIL reset_head: got %h want 0010", head_addr);
        end
        vectors++;
        if (mif.mem_rd !== 1'b0) begin
            miscompares++; $display("FAIL reset_mem_rd: got %b want 0", mif.mem_rd);
        end
        vectors++;
        if (mif.mem_addr !== 16'h0010 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_addr_uf: got %h/%b want 0010/0", mif.mem_addr, underflow);
        end
    endtask

    task automatic test_fill();
        logic [15:0] want;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 16'h0, 2'd0, 1'b1);
            want = 16'h0010 + 16'(c);
            vectors++;
            if (c < 4 && (obs_rd !== 1'b1 || obs_addr !== want)) begin
                miscompares++;
                $display("FAIL fill_addr%0d: got rd=%b addr=%h want rd=1 addr=%h",
                         c, obs_rd, obs_addr, want);
            end else if (c == 4 && obs_rd !== 1'b0) begin
                miscompares++; $display("FAIL fill_stop: got rd=%b want 0", obs_rd);
            end
        end
        vectors++;
        if (level !== 3'd4 || head_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL fill_level: got %0d/%h want 4/0010", level, head_addr);
        end
        vectors++;
        if ({q0, q1, q2} !== 24'hA90485) begin
            miscompares++; $display("FAIL fill_head: got %h%h%h want a90485", q0, q1, q2);
        end
    endtask

    task automatic test_pop();
        int n;
        tick(1'b0, 16'h0, 2'd2, 1'b1);
        vectors++;
        if (q0 !== 8'h85 || q1 !== 8'h02 || head_addr !== 16'h0012 || level !== 3'd2) begin
            miscompares++;
            $display("FAIL pop2: got q0=%h q1=%h head=%h lvl=%0d want 85 02 0012 2",
                     q0, q1, head_addr, level);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (obs_rd !== 1'b1 || obs_addr !== 16'h0014) begin
            miscompares++;
            $display("FAIL pop_resume: got rd=%b addr=%h want 1/0014", obs_rd, obs_addr);
        end
        n = 0;
        while (m_level() < 4 && n < 10) begin
            tick(1'b0, 16'h0, 2'd0, 1'b1);
            n++;
        end
        vectors++;
        if (level !== 3'd4 || q2 !== mem_img[16'h0014]) begin
            miscompares++;
            $display("FAIL pop_refill: got lvl=%0d q2=%h want 4/%h", level, q2,
                     mem_img[16'h0014]);
        end
    endtask

    task automatic test_underflow();
        logic [15:0] h;
        tick(1'b0, 16'h0, 2'd3, 1'b0);
        h = head_addr;
        vectors++;
        if (level !== 3'd1 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_setup: got lvl=%0d uf=%b want 1/0", level, underflow);
        end
        tick(1'b0, 16'h0, 2'd3, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || level !== 3'd1 || head_addr !== h) begin
            miscompares++;
            $display("FAIL uf_pulse: got uf=%b lvl=%0d head=%h want 1/1/%h",
                     underflow, level, head_addr, h);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b0);
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++; $display("FAIL uf_one_cycle: got %b want 0", underflow);
        end
        tick(1'b0, 16'h0, 2'd1, 1'b0);
        vectors++;
        if (level !== 3'd0 || head_addr !== h + 16'd1 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_then_pop: got lvl=%0d head=%h uf=%b want 0/%h/0",
                     level, head_addr, underflow, h + 16'd1);
        end
    endtask

    task automatic test_flush();
        int n = 0;
        while (m_infl == 0 && n < 10) begin
            tick(1'b0, 16'h0, 2'd0, 1'b1);
            n++;
        end
        vectors++;
        if (m_infl == 0) begin
            miscompares++; $display("FAIL flush_setup: got no read in flight want one");
        end
        tick(1'b1, 16'h0040, 2'd1, 1'b1);
        vectors++;
        if (obs_rd !== 1'b0 || level !== 3'd0 || head_addr !== 16'h0040 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_state: got rd=%b lvl=%0d head=%h uf=%b want 0/0/0040/0",
                     obs_rd, level, head_addr, underflow);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (obs_rd !== 1'b1 || obs_addr !== 16'h0040 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_first_read: got rd=%b addr=%h lvl=%0d want 1/0040/0",
                     obs_rd, obs_addr, level);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (level !== 3'd1 || q0 !== mem_img[16'h0040]) begin
            miscompares++;
            $display("FAIL flush_data: got lvl=%0d q0=%h want 1/%h", level, q0,
                     mem_img[16'h0040]);
        end
    endtask

    task automatic test_gnt_stall();
        logic [15:0] a;
        logic [2:0]  l;
        tick(1'b0, 16'h0, 2'd1, 1'b0);
        tick(1'b0, 16'h0, 2'd0, 1'b0);
        a = mif.mem_addr;
        l = level;
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 16'h0, 2'd0, 1'b0);
            vectors++;
            if (obs_rd !== 1'b1 || obs_addr !== a || level !== l) begin
                miscompares++;
                $display("FAIL stall%0d: got rd=%b addr=%h lvl=%0d want 1/%h/%0d",
                         c, obs_rd, obs_addr, level, a, l);
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 16'h0, (c == 3) ? 2'd2 : 2'd0, 1'b1);
            vectors++;
            if (level !== 3'(m_level()) || head_addr !== m_head) begin
                miscompares++;
                $display("FAIL stall_resume%0d: got lvl=%0d head=%h want %0d/%h",
                         c, level, head_addr, m_level(), m_head);
            end
            for (int k = 0; k < 3; k++) begin
                if (k < m_level()) begin
                    vectors++;
                    if (dq(k) !== m_bytes[k]) begin
                        miscompares++;
                        $display("FAIL stall_q%0d: got %h want %h", k, dq(k), m_bytes[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 16'hFFFF, 2'd0, 1'b1);
        vectors++;
        if (head_addr !== 16'hFFFF) begin
            miscompares++; $display("FAIL wrap_head0: got %h want ffff", head_addr);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (obs_addr !== 16'hFFFF || obs_rd !== 1'b1) begin
            miscompares++; $display("FAIL wrap_rd0: got %h/%b want ffff/1", obs_addr, obs_rd);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (obs_addr !== 16'h0000 || obs_rd !== 1'b1) begin
            miscompares++; $display("FAIL wrap_rd1: got %h/%b want 0000/1", obs_addr, obs_rd);
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (level !== 3'd2 || q0 !== mem_img[16'hFFFF] || q1 !== mem_img[16'h0000]) begin
            miscompares++;
            $display("FAIL wrap_data: got lvl=%0d q0=%h q1=%h want 2/%h/%h", level, q0, q1,
                     mem_img[16'hFFFF], mem_img[16'h0000]);
        end
        tick(1'b0, 16'h0, 2'd1, 1'b1);
        vectors++;
        if (head_addr !== 16'h0000 || q0 !== mem_img[16'h0000]) begin
            miscompares++;
            $display("FAIL wrap_head1: got %h/%h want 0000/%h", head_addr, q0, mem_img[16'h0000]);
        end
    endtask

    task automatic test_random();
        logic       fl;
        logic [1:0] pl;
        for (int c = 0; c < 400; c++) begin
            fl = ($urandom_range(0, 19) == 0);
            pl = 2'($urandom_range(0, 3));
            tick(fl, 16'($urandom), pl, 1'($urandom_range(0, 3) != 0));
            vectors++;
            if (obs_rd !== exp_rd || obs_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL rnd_bus%0d: got rd=%b addr=%h want rd=%b addr=%h",
                         c, obs_rd, obs_addr, exp_rd, exp_addr);
            end
            vectors++;
            if (level !== 3'(m_level()) || head_addr !== m_head || underflow !== m_uf) begin
                miscompares++;
                $display("FAIL rnd_state%0d: got lvl=%0d head=%h uf=%b want %0d/%h/%b",
                         c, level, head_addr, underflow, m_level(), m_head, m_uf);
            end
            for (int k = 0; k < 3; k++) begin
                if (k < m_level()) begin
                    vectors++;
                    if (dq(k) !== m_bytes[k]) begin
                        miscompares++;
                        $display("FAIL rnd_q%0d_%0d: got %h want %h", k, c, dq(k), m_bytes[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (m_level() == 0 && n < 10) begin
            tick(1'b0, 16'h0, 2'd0, 1'b1);
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (level !== 3'd0 || head_addr !== 16'h0010 || mif.mem_rd !== 1'b0 ||
            mif.mem_addr !== 16'h0010 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got lvl=%0d head=%h rd=%b addr=%h uf=%b want 0/0010/0/0010/0",
                     level, head_addr, mif.mem_rd, mif.mem_addr, underflow);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) tick(1'b0, 16'h0, 2'd0, 1'b1);
        vectors++;
        if (level !== 3'd4 || {q0, q1, q2} !== 24'hA90485) begin
            miscompares++;
            $display("FAIL reset_refill: got lvl=%0d head=%h%h%h want 4/a90485", level, q0, q1, q2);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem_img[a] = 8'($urandom);
        mem_img[16'h0010] = 8'hA9;
        mem_img[16'h0011] = 8'h04;
        mem_img[16'h0012] = 8'h85;
        mem_img[16'h0013] = 8'h02;
        mif.mem_gnt = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_pop();
        test_underflow();
        test_flush();
        test_gnt_stall();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
